alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, clocked successor to the 8-bit combinational flag ALU. It keeps the same 4-bit opcode map and [C V Z N] status format, generalised to WIDTH bits.
- Registered valid/ready handshakes on input and output.
- Adds a multi-cycle unsigned multiply (MUL).
- Sits between the operand/register-read stage and writeback in the mini-CPU datapath.

Parameters:
WIDTH, 8, operand width in bits (>=4); result is 2*WIDTH.
MUL_CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
enable  in  1  0 blocks new accepts (in_ready=0); in-flight work completes
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept this cycle
oparand1  in  WIDTH  operand A
oparand2  in  WIDTH  operand B
opcode  in  4  operation select
out_valid  out  1  result/status valid
out_ready  in  1  downstream accepts result
result  out  2*WIDTH  result
status  out  4  {C,V,Z,N}
illegal  out  1  high with out_valid when opcode was 1011

Behaviour:
- Reset (async, takes effect immediately, including mid-MUL): result=0, status=0, out_valid=0, illegal=0, FSM=IDLE, counter=0. in_ready is 0 while rst is high.
- Accept occurs on a clock edge where in_valid & in_ready. Operands and opcode are captured; later input changes are ignored.
- FSM states:
  - IDLE: in_ready = enable & (!out_valid | out_ready).
    - On accept of MUL -> MUL_BUSY.
    - On accept of any other opcode -> result/status registered at the same edge, out_valid=1 (latency 1). Stay in IDLE.
  - MUL_BUSY: in_ready=0. One shift-add iteration per cycle for WIDTH cycles. On the last iteration, load result and status and set out_valid=1; go to IDLE. out_valid rises WIDTH+1 edges after the accepting edge.
- Output register holds result/status/out_valid stable until out_valid & out_ready; then out_valid clears unless a new result loads at the same edge. Back-to-back throughput is 1/cycle when out_ready=1.
- Opcodes: NOT=0000, NAND=0001, NOR=0010, XOR=0011, ADD=0100, SUB=0101, AND=0110, OR=0111, RIGHT=1000, ARTH=1001, MUL=1010, reserved=1011, XNOR=1100, INC=1101, DEC=1110, LEFT=1111.
- Non-MUL results: the WIDTH-bit value R sits in result[WIDTH-1:0]; result[2W-1:W]=0.
- Z = (R==0). N = R[W-1].
- C per opcode:
  - ADD/INC: carry out.
  - SUB/DEC: borrow (unsigned A<B, or A==0 for DEC).
  - LEFT: A[W-1].
  - RIGHT/ARTH: A[0].
  - All others: 0.
- V per opcode:
  - ADD/SUB/INC/DEC: signed overflow.
  - All others: 0.
- ARTH replicates the sign bit; RIGHT and LEFT shift in 0. Unary ops (NOT, INC, DEC, shifts) ignore oparand2.
- MUL: result is the unsigned 2W product. C = V = (upper half != 0). Z = (product == 0). N = product[2W-1].
- Reserved 1011: result=0, status=4'b0010, illegal=1, latency 1.
- Wrap-around: INC of all-ones gives 0 with C=1, Z=1. DEC of 0 gives all-ones with C=1, N=1.
- enable falling during MUL_BUSY does not abort the multiply; the result is still delivered.

Optional Feature:
ALU_SAT_EN:
- Defined: on signed overflow, ADD/SUB/INC/DEC saturate to 0111..1 or 1000..0; V still reports 1 and C is unchanged.
- Undefined: results wrap modulo 2^WIDTH.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams;
  - flag bit indices (C=3, V=2, Z=1, N=0);
  - FSM state encoding (IDLE, MUL_BUSY).
- One natural sub-module, alu_mul_seq: shift-add multiplier with start/done, WIDTH-parametrised, instantiated by alu_seq.

Test Plan:
1. WIDTH=8, ADD 127+1, out_ready=1 -> next cycle result=128, status=4'b0101; ADD 255+1 -> result=0, status=4'b1010.
2. SUB 50-50 -> result=0, status=4'b0010; DEC 0 -> result=255, status=4'b1001.
3. MUL 200*3 -> in_ready low for 8 cycles, out_valid 9 edges after accept, result=600 (0x0258), status=4'b1100.
4. Back-pressure: out_ready=0 after an AND(0xAA,0xF0) -> result=0xA0 held, in_ready=0 until out_ready=1 for one cycle; a queued XOR then gives 0x5A.
5. Assert rst 4 cycles into a MUL -> outputs 0 immediately, FSM IDLE; a new ADD 1+1 after release gives result=2.
6. ARTH 0x80 -> 0xC0, N=1; opcode 1011 -> illegal=1, result=0. With ALU_SAT_EN: ADD 127+1 -> 127, status=4'b0100.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: opcode map, {C,V,Z,N} flag positions and FSM encoding.
package alu_pkg;

    localparam logic [3:0] OP_NOT   = 4'b0000;
    localparam logic [3:0] OP_NAND  = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_RIGHT = 4'b1000;
    localparam logic [3:0] OP_ARTH  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_RSVD  = 4'b1011;
    localparam logic [3:0] OP_XNOR  = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_LEFT  = 4'b1111;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: operands load on start, one iteration per clock for
// WIDTH clocks, then done pulses for one cycle with the product stable.
module alu_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;

    // Multiplicand walks left while the multiplier is consumed LSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_acc    <= '0;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Clocked WIDTH-bit flag ALU with valid/ready handshakes and a multi-cycle MUL.
// Define ALU_SAT_EN to saturate ADD/SUB/INC/DEC on signed overflow instead of wrapping.
module alu_seq #(
    parameter int WIDTH     = 8,
    parameter int MUL_CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     oparand1,
    input  logic [WIDTH-1:0]     oparand2,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           status,
    output logic                 illegal
);

    import alu_pkg::*;

    state_t               r_state;
    state_t               w_nextState;
    logic                 w_inReady;
    logic                 w_loadAlu;
    logic                 w_startMul;
    logic                 w_loadMul;

    logic [2*WIDTH-1:0]   r_result;
    logic [3:0]           r_status;
    logic                 r_outValid;
    logic                 r_illegal;

    logic [WIDTH:0]       w_addExt;
    logic [WIDTH:0]       w_subExt;
    logic [WIDTH:0]       w_incExt;
    logic [WIDTH:0]       w_decExt;
    logic [WIDTH-1:0]     w_aluRaw;
    logic [WIDTH-1:0]     w_aluRes;
    logic                 w_c;
    logic                 w_v;
    logic                 w_illegal;
    logic [3:0]           w_aluStatus;

    logic                 w_mulDone;
    logic [2*WIDTH-1:0]   w_mulProduct;
    logic [3:0]           w_mulStatus;

    assign w_addExt = {1'b0, oparand1} + {1'b0, oparand2};
    assign w_subExt = {1'b0, oparand1} - {1'b0, oparand2};
    assign w_incExt = {1'b0, oparand1} + (WIDTH + 1)'(1);
    assign w_decExt = {1'b0, oparand1} - (WIDTH + 1)'(1);

    // The top bit of each extended sum is the carry (or borrow for subtraction).
    always_comb begin
        w_aluRaw  = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_illegal = 1'b0;
        case (opcode)
            OP_NOT:   w_aluRaw = ~oparand1;
            OP_NAND:  w_aluRaw = ~(oparand1 & oparand2);
            OP_NOR:   w_aluRaw = ~(oparand1 | oparand2);
            OP_XOR:   w_aluRaw = oparand1 ^ oparand2;
            OP_XNOR:  w_aluRaw = ~(oparand1 ^ oparand2);
            OP_AND:   w_aluRaw = oparand1 & oparand2;
            OP_OR:    w_aluRaw = oparand1 | oparand2;
            OP_ADD: begin
                w_aluRaw = w_addExt[WIDTH-1:0];
                w_c      = w_addExt[WIDTH];
                w_v      = (oparand1[WIDTH-1] == oparand2[WIDTH-1]) &&
                           (w_addExt[WIDTH-1] != oparand1[WIDTH-1]);
            end
            OP_SUB: begin
                w_aluRaw = w_subExt[WIDTH-1:0];
                w_c      = w_subExt[WIDTH];
                w_v      = (oparand1[WIDTH-1] != oparand2[WIDTH-1]) &&
                           (w_subExt[WIDTH-1] != oparand1[WIDTH-1]);
            end
            OP_INC: begin
                w_aluRaw = w_incExt[WIDTH-1:0];
                w_c      = w_incExt[WIDTH];
                w_v      = !oparand1[WIDTH-1] && w_incExt[WIDTH-1];
            end
            OP_DEC: begin
                w_aluRaw = w_decExt[WIDTH-1:0];
                w_c      = w_decExt[WIDTH];
                w_v      = oparand1[WIDTH-1] && !w_decExt[WIDTH-1];
            end
            OP_RIGHT: begin
                w_aluRaw = {1'b0, oparand1[WIDTH-1:1]};
                w_c      = oparand1[0];
            end
            OP_ARTH: begin
                w_aluRaw = {oparand1[WIDTH-1], oparand1[WIDTH-1:1]};
                w_c      = oparand1[0];
            end
            OP_LEFT: begin
                w_aluRaw = {oparand1[WIDTH-2:0], 1'b0};
                w_c      = oparand1[WIDTH-1];
            end
            OP_RSVD:  w_illegal = 1'b1;
            default:  w_aluRaw = '0;
        endcase
    end

`ifdef ALU_SAT_EN
    // Every overflow case pushes toward the sign of operand A, so A's sign picks the rail.
    logic [WIDTH-1:0] w_satVal;
    assign w_satVal = oparand1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_aluRes = w_v ? w_satVal : w_aluRaw;
`else
    assign w_aluRes = w_aluRaw;
`endif

    always_comb begin
        w_aluStatus         = '0;
        w_aluStatus[FLAG_C] = w_c;
        w_aluStatus[FLAG_V] = w_v;
        w_aluStatus[FLAG_Z] = (w_aluRes == '0);
        w_aluStatus[FLAG_N] = w_aluRes[WIDTH-1];
    end

    always_comb begin
        w_mulStatus         = '0;
        w_mulStatus[FLAG_C] = (w_mulProduct[2*WIDTH-1:WIDTH] != '0);
        w_mulStatus[FLAG_V] = (w_mulProduct[2*WIDTH-1:WIDTH] != '0);
        w_mulStatus[FLAG_Z] = (w_mulProduct == '0);
        w_mulStatus[FLAG_N] = w_mulProduct[2*WIDTH-1];
    end

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (MUL_CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_startMul),
        .a       (oparand1),
        .b       (oparand2),
        .done    (w_mulDone),
        .product (w_mulProduct)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Accepting is only possible in IDLE, and only when the output slot is free or draining.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_loadAlu   = 1'b0;
        w_startMul  = 1'b0;
        w_loadMul   = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = enable & (!r_outValid | out_ready);
                if (in_valid && w_inReady) begin
                    if (opcode == OP_MUL) begin
                        w_startMul  = 1'b1;
                        w_nextState = MUL_BUSY;
                    end else begin
                        w_loadAlu = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (w_mulDone) begin
                    w_loadMul   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_status   <= '0;
            r_outValid <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_loadAlu) begin
            r_result   <= {{WIDTH{1'b0}}, w_aluRes};
            r_status   <= w_aluStatus;
            r_outValid <= 1'b1;
            r_illegal  <= w_illegal;
        end else if (w_loadMul) begin
            r_result   <= w_mulProduct;
            r_status   <= w_mulStatus;
            r_outValid <= 1'b1;
            r_illegal  <= 1'b0;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            r_illegal  <= 1'b0;
        end
    end

    assign in_ready  = w_inReady & ~rst;
    assign out_valid = r_outValid;
    assign result    = r_result;
    assign status    = r_status;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table plus random traffic through a scoreboard,
// with hand-written sequences for MUL timing, back-pressure and reset during a multiply.
module tb_alu_seq;

    import alu_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2*WIDTH-1:0] res;
        logic [3:0]         st;
        logic               ill;
    } exp_t;

    typedef struct {
        logic [3:0]         op;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        exp_t               e;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     oparand1;
    logic [WIDTH-1:0]     oparand2;
    logic [3:0]           opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic [3:0]           status;
    logic                 illegal;

    exp_t  sbQueue[$];
    vec_t  vecs[$];
    exp_t  mExp;
    int    nChecks = 0;
    int    nErrors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .oparand1  (oparand1),
        .oparand2  (oparand2),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model built from integer arithmetic rather than bit-level carries.
    function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, sv, prod;
        int umax, smax, smin;
        logic [WIDTH-1:0] r;
        logic c, v, sat;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        umax = (1 << WIDTH) - 1;
        smax = (1 << (WIDTH - 1)) - 1;
        smin = -(1 << (WIDTH - 1));
        r = '0; c = 1'b0; v = 1'b0; sat = 1'b0; sv = 0;
        e.ill = 1'b0;
        case (op)
            OP_NOT:   r = ~a;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_ADD:   begin r = WIDTH'(ua + ub); c = (ua + ub > umax); sv = sa + sb; sat = 1'b1; end
            OP_SUB:   begin r = WIDTH'(ua - ub); c = (ua < ub);        sv = sa - sb; sat = 1'b1; end
            OP_INC:   begin r = WIDTH'(ua + 1);  c = (ua == umax);     sv = sa + 1;  sat = 1'b1; end
            OP_DEC:   begin r = WIDTH'(ua - 1);  c = (ua == 0);        sv = sa - 1;  sat = 1'b1; end
            OP_RIGHT: begin r = WIDTH'(ua >> 1);  c = a[0]; end
            OP_ARTH:  begin r = WIDTH'(sa >>> 1); c = a[0]; end
            OP_LEFT:  begin r = WIDTH'(ua << 1);  c = a[WIDTH-1]; end
            OP_RSVD:  e.ill = 1'b1;
            default:  r = '0;
        endcase
        if (sat) v = (sv > smax) || (sv < smin);
`ifdef ALU_SAT_EN
        if (v) r = (sv > smax) ? WIDTH'(smax) : WIDTH'(smin);
`endif
        if (op == OP_MUL) begin
            prod  = ua * ub;
            e.res = (2*WIDTH)'(prod);
            c     = ((prod >> WIDTH) != 0);
            e.st  = {c, c, (prod == 0), e.res[2*WIDTH-1]};
        end else begin
            e.res = {{WIDTH{1'b0}}, r};
            e.st  = {c, v, (r == '0), r[WIDTH-1]};
        end
        return e;
    endfunction

    // Each accepted result is compared exactly once, on the cycle its handshake completes.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL unexpected_output: got result 0x%0h, expected no output", result);
            end else begin
                mExp = sbQueue.pop_front();
                checkOutput("result",  32'(result),  32'(mExp.res));
                checkOutput("status",  32'(status),  32'(mExp.st));
                checkOutput("illegal", 32'(illegal), 32'(mExp.ill));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input exp_t e, input bit rndReady);
        int waitCyc;
        waitCyc   = 0;
        out_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid  = 1'b1;
        opcode    = op;
        oparand1  = a;
        oparand2  = b;
        @(negedge clk);
        while (!in_ready && waitCyc < 64) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            waitCyc++;
            @(negedge clk);
        end
        if (in_ready) begin
            sbQueue.push_back(e);
        end else begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected an accept", waitCyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waitCyc;
        waitCyc   = 0;
        out_ready = 1'b1;
        while (sbQueue.size() != 0 && waitCyc < 100) begin
            @(posedge clk);
            #1;
            waitCyc++;
        end
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
    endtask

    task automatic addVec(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] res, input logic [3:0] st, input logic ill);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.e.res = res; v.e.st = st; v.e.ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        int edges, lowCnt;

`ifdef ALU_SAT_EN
        addVec(OP_ADD,   8'h7F, 8'h01, 16'h007F, 4'b0100, 1'b0);
        addVec(OP_SUB,   8'h80, 8'h01, 16'h0080, 4'b0101, 1'b0);
`else
        addVec(OP_ADD,   8'h7F, 8'h01, 16'h0080, 4'b0101, 1'b0);
        addVec(OP_SUB,   8'h80, 8'h01, 16'h007F, 4'b0100, 1'b0);
`endif
        addVec(OP_ADD,   8'hFF, 8'h01, 16'h0000, 4'b1010, 1'b0);
        addVec(OP_SUB,   8'h32, 8'h32, 16'h0000, 4'b0010, 1'b0);
        addVec(OP_DEC,   8'h00, 8'h55, 16'h00FF, 4'b1001, 1'b0);
        addVec(OP_INC,   8'hFF, 8'h00, 16'h0000, 4'b1010, 1'b0);
        addVec(OP_SUB,   8'h10, 8'h20, 16'h00F0, 4'b1001, 1'b0);
        addVec(OP_ARTH,  8'h80, 8'h00, 16'h00C0, 4'b0001, 1'b0);
        addVec(OP_RSVD,  8'h12, 8'h34, 16'h0000, 4'b0010, 1'b1);
        addVec(OP_NOT,   8'h0F, 8'hAA, 16'h00F0, 4'b0001, 1'b0);
        addVec(OP_NAND,  8'hF0, 8'hCC, 16'h003F, 4'b0000, 1'b0);
        addVec(OP_NOR,   8'hF0, 8'h0C, 16'h0003, 4'b0000, 1'b0);
        addVec(OP_XNOR,  8'hA5, 8'hA5, 16'h00FF, 4'b0001, 1'b0);
        addVec(OP_LEFT,  8'h81, 8'h00, 16'h0002, 4'b1000, 1'b0);
        addVec(OP_RIGHT, 8'h03, 8'h00, 16'h0001, 4'b1000, 1'b0);
        addVec(OP_OR,    8'h50, 8'h05, 16'h0055, 4'b0000, 1'b0);
        addVec(OP_AND,   8'h00, 8'hFF, 16'h0000, 4'b0010, 1'b0);
        addVec(OP_XOR,   8'hFF, 8'hFF, 16'h0000, 4'b0010, 1'b0);
        addVec(OP_MUL,   8'hFF, 8'hFF, 16'hFE01, 4'b1101, 1'b0);
        addVec(OP_MUL,   8'h00, 8'h05, 16'h0000, 4'b0010, 1'b0);
        addVec(OP_MUL,   8'h0F, 8'h0F, 16'h00E1, 4'b0000, 1'b0);

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        oparand1 = '0; oparand2 = '0; opcode = OP_NOT;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result",    32'(result),    32'd0);
        checkOutput("reset_status",    32'(status),    32'd0);
        checkOutput("reset_illegal",   32'(illegal),   32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] vector table: %0d entries", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b0);
        end
        drain();

        // MUL 200*3: in_ready stays low through the iterations, enable drop must not abort it.
        in_valid = 1'b1; opcode = OP_MUL; oparand1 = 8'd200; oparand2 = 8'd3;
        e.res = 16'h0258; e.st = 4'b1100; e.ill = 1'b0;
        @(negedge clk);
        checkOutput("mul_accept_ready", 32'(in_ready), 32'd1);
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0; lowCnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) enable = 1'b0;
            if (out_valid) begin
                edges = k;
                break;
            end
            if (!in_ready) lowCnt++;
        end
        enable = 1'b1;
        checkOutput("mul_latency",      32'(edges),  32'(WIDTH + 1));
        checkOutput("mul_in_ready_low", 32'(lowCnt), 32'(WIDTH));
        drain();

        // Back-pressure: AND result must hold while a queued XOR waits for the slot.
        e.res = 16'h00A0; e.st = 4'b0001; e.ill = 1'b0;
        applyStimulus(OP_AND, 8'hAA, 8'hF0, e, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = OP_XOR; oparand1 = 8'hAA; oparand2 = 8'hF0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
            checkOutput("bp_valid",    32'(out_valid), 32'd1);
            checkOutput("bp_hold",     32'(result),    32'h00A0);
            @(posedge clk);
            #1;
            oparand1 = 8'(k);
        end
        oparand1 = 8'hAA;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        e.res = 16'h005A; e.st = 4'b0000; e.ill = 1'b0;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        oparand1 = 8'h00;
        @(negedge clk);
        checkOutput("bp_xor_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_xor_held",  32'(result),    32'h005A);
        @(posedge clk);
        #1;
        drain();

        // Reset 4 cycles into a MUL clears outputs at once and the next ADD runs normally.
        e.res = 16'h0258; e.st = 4'b1100; e.ill = 1'b0;
        applyStimulus(OP_MUL, 8'd200, 8'd3, e, 1'b0);
        e.res = 16'h0258; e.st = 4'b1100;
        applyStimulus(OP_MUL, 8'd200, 8'd3, e, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid",    32'(out_valid), 32'd0);
        checkOutput("rst_mid_result",   32'(result),    32'd0);
        checkOutput("rst_mid_status",   32'(status),    32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready),  32'd0);
        sbQueue.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        e.res = 16'h0002; e.st = 4'b0000; e.ill = 1'b0;
        applyStimulus(OP_ADD, 8'd1, 8'd1, e, 1'b0);
        drain();

        // Random traffic with random downstream stalls, expectations from the model.
        for (int n = 0; n < 60; n++) begin
            logic [3:0]       rOp;
            logic [WIDTH-1:0] rA, rB;
            rOp = 4'($urandom_range(0, 15));
            rA  = WIDTH'($urandom);
            rB  = WIDTH'($urandom);
            applyStimulus(rOp, rA, rB, model(rOp, rA, rB), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
